// File: rtl/logic_unit_arbiter_pkg.sv
// Shared opcode and slot-state definitions for the logic unit arbiter.
package logic_unit_arbiter_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_NOT = 2'b10;
  localparam logic [1:0] OP_MUX = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/logic_unit_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches upward from the last granted requester, wrapping modulo R.
module rr_arbiter #(
  parameter int R = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req,
  input  logic           enable,
  input  logic           update,
  output logic [R-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] last_grant;
  logic           found;
  int             idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDW'(R - 1);
    end else if (update) begin
      last_grant <= grant_id;
    end
  end

  // Offset k=1 is the requester just after the previous winner, so it has top priority.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= R; k++) begin
      idx = (int'(last_grant) + k) % R;
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one N-bit bitwise logic unit among R requesters behind a single registered result slot.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int N = 32,
  parameter int R = 4,
  localparam int IDW = $clog2(R)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [R-1:0]     req_valid,
  output logic [R-1:0]     req_ready,
  input  logic [2*R-1:0]   req_op,
  input  logic [N*R-1:0]   req_a,
  input  logic [N*R-1:0]   req_b,
  input  logic [R-1:0]     req_sel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_data,
  output logic [IDW-1:0]   res_id
);

  slot_state_t    state, state_next;
  logic           slot_free;
  logic           transfer;
  logic [R-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic [1:0]     op_g;
  logic [N-1:0]   a_g, b_g;
  logic           sel_g;
  logic [N-1:0]   and_res, or_res, not_res, mux_res, op_result;

  assign slot_free = (state == ST_EMPTY) | res_ready;
  assign req_ready = grant;
  assign transfer  = |grant;
  assign res_valid = (state == ST_FULL);

  rr_arbiter #(.R(R)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .enable   (slot_free),
    .update   (transfer),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    op_g  = '0;
    a_g   = '0;
    b_g   = '0;
    sel_g = 1'b0;
    for (int i = 0; i < R; i++) begin
      if (grant_id == IDW'(i)) begin
        op_g  = req_op[2*i +: 2];
        a_g   = req_a[N*i +: N];
        b_g   = req_b[N*i +: N];
        sel_g = req_sel[i];
      end
    end
  end

  // Gate-array datapath: all four results are formed in parallel and the opcode picks one.
  assign and_res = a_g & b_g;
  assign or_res  = a_g | b_g;
  assign not_res = ~a_g;
  assign mux_res = sel_g ? b_g : a_g;

  always_comb begin
    op_result = and_res;
    case (op_g)
      OP_AND:  op_result = and_res;
      OP_OR:   op_result = or_res;
      OP_NOT:  op_result = not_res;
      OP_MUX:  op_result = mux_res;
      default: op_result = and_res;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A refill in the same cycle as a drain keeps the slot FULL for back-to-back results.
  always_comb begin
    state_next = state;
    if (transfer) begin
      state_next = ST_FULL;
    end else if (state == ST_FULL && res_ready) begin
      state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_id   <= '0;
    end else if (transfer) begin
      res_data <= op_result;
      res_id   <= grant_id;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench: opcode table, directed arbitration sequences and randomized traffic vs. a reference model.
module tb_logic_unit_arbiter;

  localparam int N   = 32;
  localparam int R   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [R-1:0]     req_valid;
  logic [R-1:0]     req_ready;
  logic [2*R-1:0]   req_op;
  logic [N*R-1:0]   req_a;
  logic [N*R-1:0]   req_b;
  logic [R-1:0]     req_sel;
  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_data;
  logic [IDW-1:0]   res_id;

  logic [1:0]   t_op  [R];
  logic [N-1:0] t_a   [R];
  logic [N-1:0] t_b   [R];
  logic         t_sel [R];

  for (genvar g = 0; g < R; g++) begin : g_pack
    assign req_op[2*g +: 2] = t_op[g];
    assign req_a[N*g +: N]  = t_a[g];
    assign req_b[N*g +: N]  = t_b[g];
    assign req_sel[g]       = t_sel[g];
  end

  logic_unit_arbiter #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          m_full;
  logic [31:0] m_data;
  int          m_id;
  int          m_lg;

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] refResult(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic sel);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~a;
      default: return sel ? b : a;
    endcase
  endfunction

  function automatic int refWinner(logic [R-1:0] v, int lg);
    for (int k = 1; k <= R; k++) begin
      if (v[(lg + k) % R]) return (lg + k) % R;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_full = 1'b0;
    m_data = '0;
    m_id   = 0;
    m_lg   = R - 1;
  endtask

  task automatic setReq(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic sel);
    t_op[i]  = op;
    t_a[i]   = a;
    t_b[i]   = b;
    t_sel[i] = sel;
  endtask

  task automatic applyStimulus(input logic [R-1:0] v, input logic rr);
    req_valid = v;
    res_ready = rr;
    #4;
  endtask

  task automatic checkOutput();
    int w;
    logic [R-1:0] exp_ready;
    w = (!m_full || res_ready) ? refWinner(req_valid, m_lg) : -1;
    exp_ready = (w >= 0) ? (R'(1) << w) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("res_valid", 32'(res_valid), 32'(m_full));
    check("res_data", res_data, m_data);
    check("res_id", 32'(res_id), 32'(m_id));
    if (w >= 0) begin
      m_data = refResult(t_op[w], t_a[w], t_b[w], t_sel[w]);
      m_id   = w;
      m_lg   = w;
      m_full = 1'b1;
    end else if (m_full && res_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    req_valid = '0;
    rst_n     = 1'b0;
    modelReset();
    #2;
    check("reset_valid", 32'(res_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    for (int i = 0; i < R; i++) setReq(i, 2'b00, '0, '0, 1'b0);
    modelReset();

    vecs[0] = '{2, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000};
    vecs[1] = '{0, 2'b01, 32'h0F0F_0000, 32'h0000_00F0, 1'b0, 32'h0F0F_00F0};
    vecs[2] = '{1, 2'b10, 32'h1234_5678, 32'hFFFF_0000, 1'b1, 32'hEDCB_A987};
    vecs[3] = '{3, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h1234_5678};
    vecs[4] = '{3, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'h9ABC_DEF0};
    vecs[5] = '{2, 2'b01, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF};
    vecs[6] = '{0, 2'b10, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
    vecs[7] = '{1, 2'b00, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000};

    @(posedge clk);
    #1;
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_data", res_data, 32'd0);
    check("rst_id", 32'(res_id), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-requester opcode table, one-cycle latency.
    for (int i = 0; i < 8; i++) begin
      setReq(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sel);
      applyStimulus(R'(1) << vecs[i].id, 1'b1);
      check("vec_ready", 32'(req_ready), 32'(R'(1) << vecs[i].id));
      checkOutput();
      applyStimulus('0, 1'b1);
      check("vec_valid", 32'(res_valid), 32'd1);
      check("vec_data", res_data, vecs[i].exp);
      check("vec_id", 32'(res_id), 32'(vecs[i].id));
      checkOutput();
    end

    // All requesters valid, full throughput, rotating grants.
    doReset();
    setReq(0, 2'b10, 32'h0F0F_1234, 32'h0, 1'b0);
    setReq(1, 2'b11, 32'h1111_1111, 32'h2222_2222, 1'b1);
    setReq(2, 2'b01, 32'h00FF_0000, 32'h0000_FF00, 1'b0);
    setReq(3, 2'b00, 32'hCCCC_CCCC, 32'hAAAA_AAAA, 1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus('1, 1'b1);
      check("rr_order", 32'(req_ready), 32'(R'(1) << (k % R)));
      if (k > 0) check("rr_valid", 32'(res_valid), 32'd1);
      checkOutput();
    end

    // Backpressure hold, then release grants 1 then 3.
    doReset();
    setReq(0, 2'b01, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1010, 1'b0);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_data", res_data, 32'hDEAD_BEEF);
      checkOutput();
    end
    applyStimulus(4'b1010, 1'b1);
    check("bp_release", 32'(req_ready), 32'b0010);
    checkOutput();
    applyStimulus(4'b1000, 1'b1);
    check("bp_next", 32'(req_ready), 32'b1000);
    check("bp_id", 32'(res_id), 32'd1);
    checkOutput();
    applyStimulus('0, 1'b1);
    checkOutput();

    // Pointer wrap and no idle cycle for a lone requester.
    doReset();
    applyStimulus(4'b1000, 1'b1);
    checkOutput();
    applyStimulus(4'b0001, 1'b1);
    check("wrap_ready", 32'(req_ready), 32'b0001);
    checkOutput();
    applyStimulus(4'b1000, 1'b1);
    check("lone_ready", 32'(req_ready), 32'b1000);
    checkOutput();
    applyStimulus('0, 1'b1);
    check("lone_id", 32'(res_id), 32'd3);
    checkOutput();

    // Reset mid-operation with requesters 2 and 3 pending.
    doReset();
    applyStimulus(4'b0100, 1'b1);
    checkOutput();
    applyStimulus(4'b1100, 1'b0);
    check("mid_ready", 32'(req_ready), 32'd0);
    checkOutput();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(res_valid), 32'd0);
    check("mid_data", res_data, 32'd0);
    check("mid_id", 32'(res_id), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(4'b1100, 1'b1);
    check("post_rst_ready", 32'(req_ready), 32'b0100);
    checkOutput();
    applyStimulus(4'b1000, 1'b1);
    checkOutput();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < R; i++) begin
        setReq(i, 2'($urandom), $urandom, $urandom, 1'($urandom));
      end
      applyStimulus(R'($urandom), ($urandom_range(0, 3) != 0));
      checkOutput();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
Shares one N-bit bitwise logic unit among R requesters. The unit is built from the existing andn, orn, notn and muxn gate arrays. Each requester issues an operation with a valid/ready handshake. A round-robin grant selects one request per cycle, and the result is held in a single registered output slot with a valid/ready handshake toward the consumer. The block sits between the instruction-side requesters and the shared gate datapath, and is the only block that drives that datapath's inputs.

Parameters:
N, 32, operand/result width in bits
R, 4, number of requesters; legal range 2..16
IDW, $clog2(R), requester-id width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
req_valid  input  R  per-requester request valid
req_ready  output  R  per-requester accept; one-hot or zero
req_op  input  2*R  per-requester opcode; slice i = [2i+1:2i]
req_a  input  N*R  per-requester operand a; slice i = [N*i+N-1:N*i]
req_b  input  N*R  per-requester operand b
req_sel  input  R  per-requester mux select
res_valid  output  1  result slot full
res_ready  input  1  consumer accepts result
res_data  output  N  registered result
res_id  output  IDW  index of the requester that produced res_data

Behaviour:
- Opcodes:
  - 00 AND: a&b
  - 01 OR: a|b
  - 10 NOT: ~a; b and sel are ignored
  - 11 MUX: sel=0 gives a, sel=1 gives b
- Reset (asynchronous, on rst_n low):
  - state=EMPTY, res_valid=0, res_data=0, res_id=0
  - priority pointer last_grant=R-1, so requester 0 has highest priority after reset
- FSM states:
  - EMPTY: res_valid=0
  - FULL: res_valid=1
- slot_free = (state==EMPTY) | res_ready.
- Grant:
  - When slot_free and any req_valid, the winner is the first requester with req_valid set, searching from last_grant+1 upward and wrapping modulo R.
  - req_ready[winner]=1; all other req_ready bits are 0.
  - When not slot_free, req_ready=0.
- req_ready is combinational from req_valid, state and res_ready. Requesters must not derive req_valid from req_ready.
- Transfer: on a clock edge where req_valid[w] & req_ready[w]:
  - res_data <= the op result of requester w
  - res_id <= w
  - last_grant <= w
  - state <= FULL
- Drain: res_valid & res_ready with no new grant in the same cycle → state <= EMPTY; res_data and res_id hold their last values.
- Simultaneous drain and grant: the slot is refilled in the same cycle and state stays FULL. Sustained throughput is 1 result per cycle.
- Latency: a request accepted at edge k appears on res_data/res_valid after edge k, i.e. one cycle.
- Backpressure: while FULL and res_ready=0, res_data and res_id are stable and no req_ready is asserted.
- last_grant changes only on an actual transfer. An idle cycle does not advance it.
- A single active requester is granted every free cycle; no bubbles are inserted.
- Pointer wrap: after last_grant=R-1, the search starts at 0.
- Reset mid-operation: an in-flight result is discarded and res_valid drops asynchronously. Any pending requester remains pending and is re-arbitrated from priority 0 after reset.
- Operands are sampled only on the transfer edge. Requesters must hold a/b/op/sel stable while req_valid=1 and req_ready=0.

Decomposition:
- Shared package:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_NOT=2'b10, OP_MUX=2'b11
  - FSM state encoding ST_EMPTY, ST_FULL
- Natural sub-module: rr_arbiter, parameterised by R.
  - Inputs: clk, rst_n, req[R], enable, last_grant register update.
  - Outputs: grant[R] (one-hot) and grant_id[IDW].
- The top level contains:
  - operand/op muxing by grant_id
  - the andn/orn/notn/muxn datapath
  - the output slot FSM

Test Plan:
1. Reset, then only req_valid[2]=1 with op=00, a=0xF0F0_F0F0, b=0xFF00_FF00 → req_ready[2]=1 that cycle; next cycle res_valid=1, res_data=0xF000_F000, res_id=2.
2. All four requesters valid continuously with res_ready=1 → grants 0,1,2,3,0,… on consecutive cycles, res_valid stays 1, ops NOT/MUX(sel=1)/OR checked per id.
3. Result held with res_ready=0 for 5 cycles while requesters 1 and 3 are valid → req_ready=0 throughout and res_data stable; on release, requester 1 is granted in the same cycle, then requester 3.
4. last_grant=3, requester 0 valid alone → granted (wrap); then requester 3 valid alone → granted immediately, with no extra idle cycle.
5. MUX op with a=0x1234_5678, b=0x9ABC_DEF0: sel=0 → 0x1234_5678; sel=1 → 0x9ABC_DEF0.
6. rst_n pulsed low while res_valid=1 and requesters 2 and 3 are pending → res_valid=0 immediately; after release, requester 2 is granted first.
